// File: rtl/cic_comb_decimator_comb_stage.sv
// comb_stage: one first-difference section of a CIC decimator.
// y = x - x_previous, computed modulo 2^m. The result and its valid bit are
// both registered, so each stage adds one clock of latency.
module comb_stage #(
  parameter int m = 17
) (
  input  logic                clk,
  input  logic                clr_n,
  input  logic signed [m-1:0] x,
  input  logic                x_valid,
  output logic signed [m-1:0] y,
  output logic                y_valid
);

  logic signed [m-1:0] prev;

  // Difference against the previous accepted sample, then remember this one.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      prev    <= '0;
      y       <= '0;
      y_valid <= 1'b0;
    end else begin
      y_valid <= x_valid;
      if (x_valid) begin
        y    <= x - prev;
        prev <= x;
      end
    end
  end

endmodule

// File: rtl/cic_comb_decimator.sv
// cic_comb_decimator: decimating comb half of a CIC filter.
// Samples the integrator output once every r clocks, runs it through k comb
// stages and presents the result through a 2-entry valid/ready buffer.
// All arithmetic wraps modulo 2^m so integrator wrap-around cancels exactly.
module cic_comb_decimator #(
  parameter int m = 17,
  parameter int r = 16,
  parameter int k = 1
) (
  input  logic                clk,
  input  logic                clr_n,
  input  logic signed [m-1:0] in,
  output logic signed [m-1:0] out,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                ovf
);

  localparam int cw = (r > 2) ? $clog2(r) : 1;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } fill_t;

  logic [cw-1:0]       cnt;
  logic                cap;

  // Stage chain: index 0 is the captured input, index k is the last result.
  logic signed [m-1:0] x [k+1];
  logic                v [k+1];

  logic signed [m-1:0] mem [2];
  logic                wp;
  logic                rp;
  fill_t               fill;
  logic                wr;
  logic                rd;
  logic                accept;

  assign cap = (cnt == cw'(r - 1));

  // Decimation counter 0..r-1; capture happens on the r-1 count.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt <= '0;
    end else if (cap) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign x[0] = in;
  assign v[0] = cap;

  for (genvar i = 0; i < k; i++) begin : g_comb
    comb_stage #(.m(m)) u_stage (
      .clk     (clk),
      .clr_n   (clr_n),
      .x       (x[i]),
      .x_valid (v[i]),
      .y       (x[i+1]),
      .y_valid (v[i+1])
    );
  end

  assign wr     = v[k];
  assign rd     = out_valid & out_ready;
  // A write into a full buffer is still taken when the head leaves on the
  // same edge: the slot being written is the one being read out.
  assign accept = wr & ((fill != FULL) | rd);

  // Output buffer: pointers, storage, occupancy and the sticky drop flag.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wp     <= 1'b0;
      rp     <= 1'b0;
      fill   <= EMPTY;
      ovf    <= 1'b0;
    end else begin
      if (accept) begin
        mem[wp] <= x[k];
        wp      <= ~wp;
      end
      if (rd) begin
        rp <= ~rp;
      end
      if (wr && !accept) begin
        ovf <= 1'b1;
      end
      case ({accept, rd})
        2'b10:   fill <= (fill == EMPTY) ? ONE : FULL;
        2'b01:   fill <= (fill == FULL) ? ONE : EMPTY;
        default: fill <= fill;
      endcase
    end
  end

  assign out       = mem[rp];
  assign out_valid = (fill != EMPTY);

endmodule

// File: tb/tb_cic_comb_decimator.sv
// Directed bench for cic_comb_decimator: two instances (k=1 and k=2, r=4)
// share clock, reset, input and ready; expected values are hand-computed.
module tb_cic_comb_decimator;

  logic        clk;
  logic        clr_n;
  logic [16:0] in;
  logic        out_ready;
  logic [16:0] o1, o2;
  logic        v1, v2, f1, f2;
  logic [16:0] step;
  int          n_checks;
  int          n_errors;

  cic_comb_decimator #(.m(17), .r(4), .k(1)) dut1 (
    .clk(clk), .clr_n(clr_n), .in(in), .out(o1), .out_valid(v1),
    .out_ready(out_ready), .ovf(f1)
  );

  cic_comb_decimator #(.m(17), .r(4), .k(2)) dut2 (
    .clk(clk), .clr_n(clr_n), .in(in), .out(o2), .out_valid(v2),
    .out_ready(out_ready), .ovf(f2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock: input advances by step just after the edge, then sample at negedge.
  task automatic tick();
    @(posedge clk);
    #1 in = in + step;
    @(negedge clk);
  endtask

  // Reset both DUTs and release at a negedge so the next posedge is edge 1.
  task automatic start(input logic [16:0] base, input logic [16:0] stp, input logic rdy);
    clr_n = 1'b0;
    in = base;
    step = stp;
    out_ready = rdy;
    repeat (2) @(negedge clk);
    clr_n = 1'b1;
  endtask

  logic [16:0] exp1 [4];
  logic [16:0] exp2 [4];
  logic        ev;

  initial begin
    n_checks = 0;
    n_errors = 0;
    exp1[0] = 17'd15; exp1[1] = 17'd20; exp1[2] = 17'd20; exp1[3] = 17'd20;
    exp2[0] = 17'd15; exp2[1] = 17'd5;  exp2[2] = 17'd0;  exp2[3] = 17'd0;

    // Reset state
    clr_n = 1'b0; in = 17'd123; step = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst out1", o1, 0);
    check("rst valid1", v1, 0);
    check("rst ovf1", f1, 0);
    check("rst out2", o2, 0);
    check("rst valid2", v2, 0);

    // Ramp +5: k=1 gives 15,20,20..; k=2 gives 15,5,0,0
    start(17'd0, 17'd5, 1'b1);
    for (int n = 1; n <= 17; n++) begin
      tick();
      ev = (n >= 5) && (n % 4 == 1);
      check("ramp valid1", v1, ev);
      if (ev) check("ramp out1", o1, exp1[(n-5)/4]);
      ev = (n >= 6) && (n % 4 == 2);
      check("ramp valid2", v2, ev);
      if (ev) check("ramp out2", o2, exp2[(n-6)/4]);
    end
    check("ramp ovf1", f1, 0);

    // Wrap-around: ramp +10000, first 30000 then 40000 across 17-bit wrap
    start(17'd0, 17'd10000, 1'b1);
    for (int n = 1; n <= 21; n++) begin
      tick();
      ev = (n >= 5) && (n % 4 == 1);
      check("wrap valid", v1, ev);
      if (ev) check("wrap out", o1, (n == 5) ? 30000 : 40000);
    end

    // Full buffer with simultaneous read: no drop
    start(17'd0, 17'd5, 1'b0);
    for (int n = 1; n <= 12; n++) tick();
    check("fullrd valid", v1, 1);
    check("fullrd head", o1, 15);
    out_ready = 1'b1;
    tick();                       // edge 13: read 15, write 20 while full
    out_ready = 1'b0;
    check("fullrd ovf", f1, 0);
    check("fullrd head2", o1, 20);
    tick();                       // edge 14: idle, still two entries
    out_ready = 1'b1;
    tick();                       // edge 15: one left
    check("fullrd left1", v1, 1);
    check("fullrd out3", o1, 20);
    tick();                       // edge 16: empty
    check("fullrd empty", v1, 0);
    check("fullrd ovf end", f1, 0);

    // Backpressure and overflow
    start(17'd0, 17'd5, 1'b0);
    for (int n = 1; n <= 12; n++) tick();
    check("bp valid", v1, 1);
    check("bp head", o1, 15);
    check("bp ovf before", f1, 0);
    tick();                       // edge 13: third sample dropped
    check("bp ovf set", f1, 1);
    check("bp head kept", o1, 15);
    out_ready = 1'b1;
    tick();                       // edge 14
    check("bp drain1 valid", v1, 1);
    check("bp drain1 out", o1, 20);
    tick();                       // edge 15
    check("bp drained", v1, 0);
    check("bp ovf sticky", f1, 1);
    tick(); tick();               // edge 17: next sample
    check("bp next valid", v1, 1);
    check("bp next out", o1, 20);
    tick(); tick(); tick();       // edge 20: capture, sample in flight

    // Reset mid-stream, asynchronous, between edges
    #1 clr_n = 1'b0;
    #1;
    check("mid rst out1", o1, 0);
    check("mid rst valid1", v1, 0);
    check("mid rst ovf1", f1, 0);
    check("mid rst ovf2", f2, 0);
    check("mid rst valid2", v2, 0);
    in = 17'd1000; step = 17'd7;
    #1 clr_n = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      tick();
      check("post rst valid1", v1, n == 5);
      if (n == 5) check("post rst out1", o1, 1021);
      check("post rst valid2", v2, n == 6);
      if (n == 6) check("post rst out2", o2, 1021);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
